mode_sequencer: RTL

Registered controller that arbitrates the shared state datapath between the three operation modes (linked-list walk LNK, random generator RND, FBCV) and sequences each granted operation through fetch, execute and an optional extra execute phase. It replaces free-running combinational next-state decoding with a clocked Moore FSM and a round-robin arbiter. It sits between the mode request sources and the datapath's fetch/execute enables.

---
 rtl/mode_sequencer_pkg.sv | 33 +++
 rtl/mode_sequencer_if.sv | 29 ++
 rtl/mode_sequencer_rr_pick.sv | 39 +++
 rtl/mode_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer: state codes, requester indices
// and the round-robin index helper.
package mode_sequencer_pkg;

  // Number of requesting modes.
  localparam int unsigned REQ_CNT = 3;

  // Requester indices.
  localparam logic [1:0] IDX_LNK  = 2'd0;
  localparam logic [1:0] IDX_RND  = 2'd1;
  localparam logic [1:0] IDX_FBCV = 2'd2;

  // Sequencer state codes; the codes 3'b101..3'b111 are unused.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FETCH = 3'b001,
    ST_EXEC  = 3'b010,
    ST_EXTRA = 3'b011,
    ST_DONE  = 3'b100
  } state_e;

  // Next requester index in round-robin order. Out-of-range indices wrap to LNK.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    logic [1:0] nxt;
    if (idx >= IDX_FBCV) begin
      nxt = IDX_LNK;
    end else begin
      nxt = idx + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Request/grant and datapath-control bundle between the mode sources,
// the datapath and the mode sequencer.
interface mode_sequencer_if;
  import mode_sequencer_pkg::*;

  logic [REQ_CNT-1:0] req;
  logic               extra;
  logic               step_done;
  logic [REQ_CNT-1:0] gnt;
  logic [2:0]         state_out;
  logic               busy;
  logic               fetch_en;
  logic               exec_en;
  logic               done;
  logic               timeout;

  // Requester/datapath side.
  modport master (
    output req, extra, step_done,
    input  gnt, state_out, busy, fetch_en, exec_en, done, timeout
  );

  // Sequencer side.
  modport slave (
    input  req, extra, step_done,
    output gnt, state_out, busy, fetch_en, exec_en, done, timeout
  );

endinterface

// File: rtl/mode_sequencer_rr_pick.sv
// Combinational round-robin selector: searches the requests starting at the
// index after the last winner and returns the first one found.
module rr_pick
  import mode_sequencer_pkg::*;
(
  input  logic [REQ_CNT-1:0] req,
  input  logic [1:0]         last,
  output logic [REQ_CNT-1:0] win,
  output logic [1:0]         idx
);

  logic [1:0] c0_s;
  logic [1:0] c1_s;
  logic [1:0] c2_s;

  assign c0_s = rr_next(last);
  assign c1_s = rr_next(c0_s);
  assign c2_s = rr_next(c1_s);

  // Take the first active request in rotated priority order.
  always_comb begin
    win = 3'b000;
    idx = 2'd0;
    if (req[c0_s]) begin
      win = 3'b001 << c0_s;
      idx = c0_s;
    end else if (req[c1_s]) begin
      win = 3'b001 << c1_s;
      idx = c1_s;
    end else if (req[c2_s]) begin
      win = 3'b001 << c2_s;
      idx = c2_s;
    end else begin
      win = 3'b000;
      idx = 2'd0;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Moore sequencer arbitrating the shared datapath between LNK, RND and FBCV
// and stepping each grant through fetch, execute and an optional extra
// execute phase, with a per-phase timeout.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  mode_sequencer_if.slave bus
);

  // Counter is just wide enough to reach TIMEOUT-1.
  localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [REQ_CNT-1:0] gnt_r;
  logic [1:0]         gidx_r;
  logic [1:0]         last_r;
  logic               extra_r;
  logic               to_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [REQ_CNT-1:0] win_s;
  logic [1:0]         win_idx_s;
  logic               phase_last_s;

  logic               busy_s;
  logic               fetch_en_s;
  logic               exec_en_s;
  logic               done_s;
  logic               timeout_s;

  rr_pick u_rr_pick (
    .req  (bus.req),
    .last (last_r),
    .win  (win_s),
    .idx  (win_idx_s)
  );

  assign phase_last_s = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; step_done beats a simultaneous final timeout count.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.req != 3'b000) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: state_nxt_s = ST_EXEC;
      ST_EXEC: begin
        if (bus.step_done) begin
          if (extra_r) begin
            state_nxt_s = ST_EXTRA;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else if (phase_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXTRA: begin
        if (bus.step_done || phase_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXTRA;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant, round-robin history, extra/timeout flags and the phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r   <= 3'b000;
      gidx_r  <= 2'd0;
      last_r  <= IDX_FBCV;
      extra_r <= 1'b0;
      to_r    <= 1'b0;
      cnt_r   <= CNT_W'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req != 3'b000) begin
            gnt_r  <= win_s;
            gidx_r <= win_idx_s;
          end
        end
        ST_FETCH: begin
          extra_r <= bus.extra;
          cnt_r   <= CNT_W'(0);
        end
        ST_EXEC: begin
          if (bus.step_done) begin
            cnt_r <= CNT_W'(0);
          end else if (phase_last_s) begin
            to_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_EXTRA: begin
          if (!bus.step_done) begin
            if (phase_last_s) begin
              to_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          last_r  <= gidx_r;
          gnt_r   <= 3'b000;
          gidx_r  <= 2'd0;
          extra_r <= 1'b0;
          to_r    <= 1'b0;
          cnt_r   <= CNT_W'(0);
        end
        default: begin
          gnt_r   <= 3'b000;
          gidx_r  <= 2'd0;
          extra_r <= 1'b0;
          to_r    <= 1'b0;
          cnt_r   <= CNT_W'(0);
        end
      endcase
    end
  end

  // Moore output decode from the registered state and flags.
  always_comb begin
    busy_s     = 1'b0;
    fetch_en_s = 1'b0;
    exec_en_s  = 1'b0;
    done_s     = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE:  busy_s = 1'b0;
      ST_FETCH: begin
        busy_s     = 1'b1;
        fetch_en_s = 1'b1;
      end
      ST_EXEC, ST_EXTRA: begin
        busy_s    = 1'b1;
        exec_en_s = 1'b1;
      end
      ST_DONE: begin
        busy_s    = 1'b1;
        done_s    = 1'b1;
        timeout_s = to_r;
      end
      default: busy_s = 1'b1;
    endcase
  end

  assign bus.gnt       = gnt_r;
  assign bus.state_out = state_r;
  assign bus.busy      = busy_s;
  assign bus.fetch_en  = fetch_en_s;
  assign bus.exec_en   = exec_en_s;
  assign bus.done      = done_s;
  assign bus.timeout   = timeout_s;

endmodule
